param_memory: RTL and testbench



---
 rtl/param_memory.sv | 87 ++++++++
 tb/tb_param_memory.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/param_memory.sv
// ---------------------------------------------------------------------------
// param_memory
//   Parameterised single-port synchronous RAM with one shared address, a
//   write enable and a registered read port. Every edge performs a read of
//   mem[address]; a write is performed in addition when write_enable is high.
//   All storage and the read register clear to zero on reset.
//
//   Parameters:
//     DATA_WIDTH  word width
//     ADDR_WIDTH  address width
//     DEPTH       number of words, 1..2**ADDR_WIDTH
//
//   Ports:
//     clk           in   clock, rising edge
//     rst_n         in   asynchronous active-low reset
//     write_enable  in   write data_in to mem[address] on this edge
//     address       in   word address shared by read and write
//     data_in       in   write data
//     data_out      out  registered read data
//
//   Build option:
//     PARAM_MEMORY_WRITE_THROUGH_EN  defined: write-first (data_out gets the
//                                    written word on a write edge).
//                                    undefined: read-first (data_out gets the
//                                    pre-write word).
// ---------------------------------------------------------------------------
module param_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    // Out-of-range addresses never reach the array: writes are dropped and
    // reads return zero, so no aliasing onto in-range words is possible.
    assign in_range = ({1'b0, address} < DEPTH_W);
    assign idx      = address[IDX_W-1:0];

    always_comb begin
        rdata_d = '0;
        if (in_range) begin
            rdata_d = mem_q[idx];
        end
`ifdef PARAM_MEMORY_WRITE_THROUGH_EN
        if (write_enable) begin
            rdata_d = in_range ? data_in : '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_enable && in_range) begin
            mem_q[idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign data_out = rdata_q;

endmodule

// File: tb/tb_param_memory.sv
// ---------------------------------------------------------------------------
// tb_param_memory
//   Scoreboard bench for param_memory (DEPTH=200, so out-of-range handling is
//   exercised). The driver applies one operation per cycle at the falling
//   edge and queues the hand-computed data_out expected after the next rising
//   edge; the monitor checks queued entries 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_param_memory;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DP = 200;

    logic          clk;
    logic          rst_n;
    logic          write_enable;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;

    typedef struct {
        int          cyc;
        logic [DW-1:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        cyc_cnt  = 0;
    int        pass_cnt = 0;
    int        total_cnt = 0;

    param_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected data_out on a write edge: old word (read-first) or new word.
`ifdef PARAM_MEMORY_WRITE_THROUGH_EN
    function automatic logic [DW-1:0] wr_exp(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w);
        return new_w;
    endfunction
`else
    function automatic logic [DW-1:0] wr_exp(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w);
        return old_w;
    endfunction
`endif

    task automatic check_now(input string name, input logic [DW-1:0] exp);
        total_cnt++;
        if (data_out === exp) pass_cnt++;
        else $display("FAIL %s: data_out=%0d expected=%0d", name, data_out, exp);
    endtask

    // Monitor: pops every entry due on this cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt++;
            #1;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
                sb_entry_t e;
                e = sb_q.pop_front();
                total_cnt++;
                if (e.cyc != cyc_cnt)
                    $display("FAIL %s: sampled at cycle %0d, due at cycle %0d", e.name, cyc_cnt, e.cyc);
                else if (data_out === e.exp)
                    pass_cnt++;
                else
                    $display("FAIL %s: data_out=%0d expected=%0d", e.name, data_out, e.exp);
            end
        end
    end

    task automatic op(input logic we, input int addr, input int din,
                      input logic [DW-1:0] exp, input string name);
        @(negedge clk);
        write_enable = we;
        address      = AW'(addr);
        data_in      = DW'(din);
        sb_q.push_back('{cyc: cyc_cnt + 1, exp: exp, name: name});
    endtask

    task automatic rd(input int addr, input logic [DW-1:0] exp, input string name);
        op(1'b0, addr, 0, exp, name);
    endtask

    task automatic wr(input int addr, input int din, input logic [DW-1:0] exp, input string name);
        op(1'b1, addr, din, exp, name);
    endtask

    task automatic drain();
        int budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            write_enable = 1'b0;
            budget--;
        end
        while (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            total_cnt++;
            $display("FAIL %s: timeout, no sample taken, expected=%0d", e.name, e.exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        data_in      = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_now("reset_dout", 8'd0);

        for (int a = 0; a < 256; a++) rd(a, 8'd0, "reset_read");

        wr(5, 45, wr_exp(8'd0, 8'd45), "wr_45_at_5");
        wr(0, 77, wr_exp(8'd0, 8'd77), "wr_77_at_0");
        wr(3, 32, wr_exp(8'd0, 8'd32), "wr_32_at_3");
        rd(5, 8'd45, "rd_5");
        rd(0, 8'd77, "rd_0");
        rd(3, 8'd32, "rd_3");
        rd(10, 8'd0, "rd_unwritten_10");

        wr(20, 12, wr_exp(8'd0, 8'd12), "collide_wr_20");
        rd(20, 8'd12, "collide_rd_20");

        wr(7, 1, wr_exp(8'd0, 8'd1), "same_addr_wr1");
        wr(7, 2, wr_exp(8'd1, 8'd2), "same_addr_wr2");
        rd(7, 8'd2, "last_write_wins");

        wr(199, 55, wr_exp(8'd0, 8'd55), "wr_top_199");
        wr(50, 88, wr_exp(8'd0, 8'd88), "wr_50");
        wr(250, 99, 8'd0, "oor_wr_250");
        rd(250, 8'd0, "oor_rd_250");
        rd(199, 8'd55, "top_199_intact");
        rd(249, 8'd0, "oor_rd_249");
        rd(50, 8'd88, "alias_50_intact");
        rd(5, 8'd45, "rd_5_again");
        drain();

        // Asynchronous reset between edges while data_out holds 45.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_dout", 8'd0);
        write_enable = 1'b1;
        address      = AW'(5);
        data_in      = DW'(123);
        repeat (2) @(posedge clk);
        #1;
        check_now("dout_held_in_reset", 8'd0);
        @(negedge clk);
        write_enable = 1'b0;
        rst_n = 1'b1;

        rd(5, 8'd0, "post_reset_rd_5");
        rd(0, 8'd0, "post_reset_rd_0");
        rd(3, 8'd0, "post_reset_rd_3");
        rd(50, 8'd0, "post_reset_rd_50");
        rd(199, 8'd0, "post_reset_rd_199");
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
